// File: rtl/key_event_scheduler.sv
// key_event_scheduler: debounced key press/release events, round-robin merged into
// an event FIFO that the CPU pops through a 4-word Avalon-MM slave with a level IRQ.
module key_event_scheduler #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] in_port,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);
  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pending_q, pending_d;
  logic [NUM_KEYS-1:0] ptype_q, ptype_d;
  logic [1:0]          rr_q, rr_d;
  logic [2:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                irq_en_q, irq_en_d;
  logic                rel_en_q, rel_en_d;
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q, irq_d;

  logic [NUM_KEYS-1:0] pressed_sync, pulse, accept;
  logic [NUM_KEYS-1:0] grant_oh;
  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic                fifo_full, fifo_empty;
  logic                rd_en, wr_en, pop, push, flush, ovf_clr, ovf_set, ctrl_wr;
  logic [3:0]          mask_wr;
  logic [2:0]          head;
  logic                unused_wdata;

  assign pressed_sync = ~sync2_q;
  assign fifo_full    = (count_q == CNT_FULL);
  assign fifo_empty   = (count_q == '0);
  assign head         = mem_q[rd_q];

  assign rd_en   = chipselect & read;
  assign wr_en   = chipselect & write;
  assign pop     = rd_en & (address == 2'd0) & ~fifo_empty;
  assign flush   = wr_en & (address == 2'd3) & writedata[0];
  assign ovf_clr = wr_en & (address == 2'd3) & writedata[16];
  assign ctrl_wr = wr_en & (address == 2'd2);
  assign push    = grant_vld & ~flush;
  assign mask_wr = writedata[7:4];
  assign unused_wdata = ^{writedata[31:17], writedata[15:8], writedata[3:2], mask_wr};

  always_comb begin
    stable_d = stable_q;
    pulse    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (pressed_sync[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          stable_d[k] = pressed_sync[k];
          pulse[k]    = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
    accept = pulse & mask_q & (pressed_sync | {NUM_KEYS{rel_en_q}});
  end

  // Round-robin search starting at rr_q; a full FIFO blocks every grant.
  always_comb begin
    int c;
    logic [1:0] cand;
    c         = 0;
    cand      = 2'd0;
    grant_vld = 1'b0;
    grant_oh  = '0;
    grant_idx = 2'd0;
    rr_d      = rr_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      c    = (int'(rr_q) + i >= NUM_KEYS) ? int'(rr_q) + i - NUM_KEYS : int'(rr_q) + i;
      cand = 2'(c);
      if (!grant_vld && !fifo_full && pending_q[cand]) begin
        grant_vld      = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
        rr_d           = (c + 1 >= NUM_KEYS) ? 2'd0 : 2'(c + 1);
      end else begin
        grant_vld = grant_vld;
      end
    end
  end

  // A granted key may be re-armed in the same cycle; only an unserved pending is overwritten.
  assign pending_d = (pending_q & ~grant_oh) | accept;
  assign ptype_d   = (ptype_q & ~accept) | (pressed_sync & accept);
  assign ovf_set   = (flush & grant_vld) | (|(accept & pending_q & ~grant_oh));
  assign ovf_d     = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  assign irq_en_d = ctrl_wr ? writedata[0] : irq_en_q;
  assign rel_en_d = ctrl_wr ? writedata[1] : rel_en_q;
  assign mask_d   = ctrl_wr ? mask_wr[NUM_KEYS-1:0] : mask_q;
  assign irq_d    = irq_en_d & (count_d != '0);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      wr_d = push ? wr_q + AW'(1) : wr_q;
      rd_d = pop  ? rd_q + AW'(1) : rd_q;
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (address)
        2'd0: begin
          if (!fifo_empty) begin
            rdata_d[31]  = 1'b1;
            rdata_d[8]   = head[2];
            rdata_d[1:0] = head[1:0];
          end else begin
            rdata_d = '0;
          end
        end
        2'd1: begin
          rdata_d[NUM_KEYS-1:0] = stable_q;
          rdata_d[8 +: AW+1]    = count_q;
          rdata_d[16]           = ovf_q;
          rdata_d[17]           = fifo_full;
        end
        2'd2: begin
          rdata_d[0]            = irq_en_q;
          rdata_d[1]            = rel_en_q;
          rdata_d[4 +: NUM_KEYS] = mask_q;
        end
        default: rdata_d = '0;
      endcase
    end else begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      stable_q  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
      pending_q <= '0;
      ptype_q   <= '0;
      rr_q      <= 2'd0;
      for (int e = 0; e < FIFO_DEPTH; e++) mem_q[e] <= 3'd0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      rel_en_q  <= 1'b0;
      mask_q    <= '0;
      rdata_q   <= 32'd0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
      pending_q <= pending_d;
      ptype_q   <= ptype_d;
      rr_q      <= rr_d;
      if (push) mem_q[wr_q] <= {ptype_q[grant_idx], grant_idx};
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      rel_en_q  <= rel_en_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
endmodule

// File: doc/key_event_scheduler.md
Name: key_event_scheduler

Overview:
- Debounces NUM_KEYS push-button inputs and detects press and release events on the clean levels.
- Arbitrates simultaneous events round-robin into one ordered event FIFO.
- Exposes the FIFO and its control/status registers to the Nios II through a 4-word Avalon-MM slave, with a level IRQ.
- Replaces raw edge-capture PIO use for keys, so software pops timestamp-ordered, bounce-free key events instead of polling edge bits.

Parameters:
- NUM_KEYS, 4, number of key inputs (2..4; event index field is 2 bits).
- DEBOUNCE_CYCLES, 50000, cycles a synchronized level must stay stable before it is accepted (≥2).
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_port  in  NUM_KEYS  raw keys, active-low (0 = pressed).
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Clock/reset: single clock clk. Reset is synchronous, active-high, on port reset. It clears all state:
  - sync flops = 1 (released), stable = released, counters = 0;
  - pending = 0, RR pointer = 0, FIFO empty, overflow = 0, CONTROL = 0;
  - readdata = 0, irq = 0.
  - Reset mid-debounce or mid-arbitration discards everything. No event is emitted on the cycle after reset.
- Synchronizer: 2 flops per key. pressed_sync[k] = ~in_port after sync.
- Debounce, per key:
  - If pressed_sync != stable, cnt increments. When cnt == DEBOUNCE_CYCLES-1, stable <= pressed_sync, cnt <= 0, and a 1-cycle event pulse fires (type 1 = press, 0 = release).
  - If pressed_sync == stable, cnt <= 0. Any bounce restarts the count.
- Event filtering: a pulse sets pending[k] and ptype[k] only if CONTROL.mask[k]=1. A release additionally requires CONTROL.rel_en=1.
  - If pending[k] is already set when a new pulse arrives, ptype[k] is overwritten with the newest value and STATUS.ovf is set (sticky).
- Arbiter:
  - Each cycle, if FIFO not full and any pending is set, grant the first pending key searching from rr_ptr upward, modulo NUM_KEYS.
  - Push {ptype, index}, clear that pending bit, set rr_ptr = granted+1 mod NUM_KEYS.
  - One push per cycle maximum. FIFO full → pending is held, not lost.
  - A pulse and a grant for the same key in the same cycle: the grant pushes the old ptype, and pending stays set with the new ptype.
- FIFO:
  - Pop when chipselect & read & address==0 & not empty.
  - Simultaneous push and pop: count unchanged.
  - Pop when empty: no effect.
  - Flush, which clears the FIFO but not pending, wins over a push in the same cycle; that pushed event is lost and ovf is set.
- Register map:
  - Reads return one cycle after the strobe (registered readdata). Unused bits read 0.
  - 0 EVENT (R, pops): [31] valid = !empty, [8] type, [1:0] index. Empty → all 0.
  - 1 STATUS (R): [3:0] stable levels, [12:8] fifo count, [16] ovf, [17] full.
  - 2 CONTROL (R/W): [0] irq_en, [1] rel_en, [7:4] mask.
  - 3 COMMAND (W): [0]=1 flush FIFO, [16]=1 clear ovf. Reads return 0.
  - A write to address 0 or 1 is ignored.
- IRQ: irq = irq_en & !empty, registered. It deasserts the cycle after the pop that empties the FIFO.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=8, mask=F, rel_en=1, irq_en=1.
- Debounce: hold key0 low for 5 cycles, release 3 cycles, then hold low 12 cycles → no event from the first pulse; exactly one press event. EVENT read = 0x8000_0100, irq asserts, then deasserts after the pop.
- Round-robin: keys 1, 2, 3 pressed in the same cycle with rr_ptr=2 → FIFO order is idx 2, 3, 1. A later simultaneous press of keys 0 and 2 gives idx 2 then 0 (ptr=2 after granting 1).
- Full/backpressure: FIFO_DEPTH=8; generate 10 events without reading → count=8, full=1, 2 pending held. Pop 1 → 1 pending pushed next cycle, count stays 8. All 10 events are eventually read in order, and ovf stays 0.
- Overwrite/ovf: with key3 masked out of the FIFO path by filling the FIFO, press then release key3 → single pending with type release, ovf=1. Write COMMAND 0x1_0000 → ovf=0.
- Simultaneity and reset: issue flush and push in the same cycle → count 0, ovf=1. Pop and push in the same cycle → count unchanged. Assert reset during debounce count 5 → after reset there are no events, readdata=0, irq=0.
- Filtering: rel_en=0, mask=0x1 → key1 presses are ignored and key0 releases are ignored. Read of CONTROL returns 0x0000_0011 (irq_en=1, mask=1).
